alu_md: RTL and testbench
=========================

ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64, even.
REQ-002 Parameter OPT_W, default 5, opcode width.
REQ-003 Parameter BR_ON_OUT, default 0; when 1, branch_enable is also copied to out[0] for compare ops.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  request presents alu_opt, a, b.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 alu_opt  input  OPT_W  operation select.
REQ-009 a, b  input  XLEN each  operands.
REQ-010 flush  input  1  abort any in-flight or held operation.
REQ-011 out_valid  output  1  result held on out/branch_enable.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 out  output  XLEN  registered result.
REQ-014 branch_enable  output  1  registered branch decision.
REQ-015 busy  output  1  high while in CALC.

Function
REQ-016 Transfer occurs on in_valid && in_ready at a rising edge; result transfer on out_valid && out_ready.
REQ-017 Opcodes 0x00..0x11 keep existing ALU semantics: add, sub, and, or, xor, sll, slt, sltu, srl, shift-imm (b[11]? sll : sra), addr-add, beq, bne, blt, bge, bltu, bgeu, pass-b; shift amounts use b[$clog2(XLEN)-1:0].
REQ-018 New opcodes: 0x12 MUL, 0x13 MULH, 0x14 MULHSU, 0x15 MULHU, 0x16 DIV, 0x17 DIVU, 0x18 REM, 0x19 REMU (RISC-V M semantics); 0x1A..max return out=0, branch_enable=0.
REQ-019 FSM states IDLE, CALC, DONE; IDLE->DONE for single-cycle ops, IDLE->CALC for 0x12..0x19, CALC->DONE after XLEN iterations, DONE->IDLE on out_ready && !in_valid.
REQ-020 Single-cycle ops: out_valid rises on the edge after accept (latency 1).
REQ-021 M ops: one radix-2 iteration per cycle, out_valid rises exactly XLEN+1 edges after accept, independent of operand values.
REQ-022 in_ready = (state==IDLE) || (state==DONE && out_ready); back-to-back accept in DONE gives one result per cycle for single-cycle ops.
REQ-023 out_valid held with out/branch_enable stable until out_ready; no result ever dropped.
REQ-024 Non-compare ops drive branch_enable=0; compare ops drive out=0 unless BR_ON_OUT=1.
REQ-025 Multiplier: 2*XLEN product, signed/unsigned operand extension per opcode; MUL returns low half, MULH* high half.
REQ-026 Divide by zero: DIV/DIVU -> all ones, REM/REMU -> a; full XLEN+1 latency retained.
REQ-027 Signed overflow (a = most negative, b = -1): DIV -> a, REM -> 0.
REQ-028 Signed division truncates toward zero; remainder sign follows dividend.
REQ-029 flush: state->IDLE, out_valid->0 next edge, in-flight result discarded; flush wins over simultaneous accept.

Reset
REQ-030 rst_n low: state=IDLE, out_valid=0, out=0, branch_enable=0, busy=0, iteration counter=0, immediately and asynchronously.
REQ-031 Reset mid-CALC discards the operation; in_ready high on first edge after release.

Structure
REQ-032 Opcode constants, FSM state enum and XLEN default live in shared package alu_md_pkg, used by decoder and tests.
REQ-033 Combinational single-cycle datapath is one sub-module, alu_core; shift-add/shift-subtract engine stays in alu_md.

Verification
REQ-034 ADD a=5,b=7 accepted, out_ready=1 -> next cycle out_valid=1, out=12, branch_enable=0.
REQ-035 BLT a=0xFFFFFFFF,b=1 -> branch_enable=1; BLTU same operands -> branch_enable=0.
REQ-036 MULH a=0x80000000,b=0x80000000 -> out=0x40000000 exactly 33 edges after accept; in_ready=0 throughout CALC.
REQ-037 DIV a=0x80000000,b=0xFFFFFFFF -> out=0x80000000; REM same -> 0; DIVU a=9,b=0 -> 0xFFFFFFFF; REMU -> 9.
REQ-038 DIVU 100/7 with out_ready=0 for 5 cycles after completion -> out=14 held stable, then transfers once.
REQ-039 Flush at cycle 10 of a DIV, then rst_n pulse during a MUL -> no out_valid for either, next ADD 1+1 returns 2 at latency 1.

Source files
------------

// File: rtl/alu_md_pkg.sv
// Shared opcode map, FSM state encoding and default widths for the ALU with
// multiply/divide extension.
package alu_md_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int OPT_W_DEFAULT = 5;

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SUB    = 5'h01;
  localparam logic [4:0] OP_AND    = 5'h02;
  localparam logic [4:0] OP_OR     = 5'h03;
  localparam logic [4:0] OP_XOR    = 5'h04;
  localparam logic [4:0] OP_SLL    = 5'h05;
  localparam logic [4:0] OP_SLT    = 5'h06;
  localparam logic [4:0] OP_SLTU   = 5'h07;
  localparam logic [4:0] OP_SRL    = 5'h08;
  localparam logic [4:0] OP_SHIMM  = 5'h09;
  localparam logic [4:0] OP_ADDR   = 5'h0A;
  localparam logic [4:0] OP_BEQ    = 5'h0B;
  localparam logic [4:0] OP_BNE    = 5'h0C;
  localparam logic [4:0] OP_BLT    = 5'h0D;
  localparam logic [4:0] OP_BGE    = 5'h0E;
  localparam logic [4:0] OP_BLTU   = 5'h0F;
  localparam logic [4:0] OP_BGEU   = 5'h10;
  localparam logic [4:0] OP_PASSB  = 5'h11;
  localparam logic [4:0] OP_MUL    = 5'h12;
  localparam logic [4:0] OP_MULH   = 5'h13;
  localparam logic [4:0] OP_MULHSU = 5'h14;
  localparam logic [4:0] OP_MULHU  = 5'h15;
  localparam logic [4:0] OP_DIV    = 5'h16;
  localparam logic [4:0] OP_DIVU   = 5'h17;
  localparam logic [4:0] OP_REM    = 5'h18;
  localparam logic [4:0] OP_REMU   = 5'h19;
  localparam logic [4:0] OP_NONE   = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  function automatic logic is_m_op(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_md_core.sv
// Combinational single-cycle ALU: arithmetic, logic, shifts, set-less-than
// and branch compares.
module alu_core
  import alu_md_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int BR_ON_OUT = 0
) (
  input  logic [4:0]      opt,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            branch_enable
);

  localparam int SW   = $clog2(XLEN);
  localparam int IMMB = (XLEN > 11) ? 11 : XLEN - 1;

  logic [SW-1:0] shamt;
  logic          eq;
  logic          lt_s;
  logic          lt_u;
  logic          is_cmp;

  assign shamt  = b[SW-1:0];
  assign eq     = (a == b);
  assign lt_s   = ($signed(a) < $signed(b));
  assign lt_u   = (a < b);
  assign is_cmp = (opt >= OP_BEQ) && (opt <= OP_BGEU);

  always_comb begin
    result        = '0;
    branch_enable = 1'b0;
    case (opt)
      OP_ADD,
      OP_ADDR:  result = a + b;
      OP_SUB:   result = a - b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_SLL:   result = a << shamt;
      OP_SLT:   result = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU:  result = {{(XLEN-1){1'b0}}, lt_u};
      OP_SRL:   result = a >> shamt;
      OP_SHIMM: result = b[IMMB] ? (a << shamt) : $unsigned($signed(a) >>> shamt);
      OP_BEQ:   branch_enable = eq;
      OP_BNE:   branch_enable = !eq;
      OP_BLT:   branch_enable = lt_s;
      OP_BGE:   branch_enable = !lt_s;
      OP_BLTU:  branch_enable = lt_u;
      OP_BGEU:  branch_enable = !lt_u;
      OP_PASSB: result = b;
      default:  result = '0;
    endcase
    // Some consumers read the branch decision from the data path instead.
    if ((BR_ON_OUT != 0) && is_cmp)
      result = {{(XLEN-1){1'b0}}, branch_enable};
  end

endmodule

// File: rtl/alu_md.sv
// ALU with valid/ready handshake and an iterative radix-2 multiply/divide
// engine; single-cycle ops come from alu_core.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int OPT_W     = OPT_W_DEFAULT,
  parameter int BR_ON_OUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPT_W-1:0] alu_opt,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out,
  output logic             branch_enable,
  output logic             busy
);

  localparam int CW = $clog2(XLEN + 1);

  state_t          state, state_nx;
  logic [4:0]      op_n, op_q;
  logic [XLEN-1:0] acc_hi, acc_lo, mcand, a_q, out_r;
  logic            be_r, neg_q, neg_r, b_zero;
  logic [CW-1:0]   cnt;

  logic [XLEN-1:0] core_res;
  logic            core_be;
  logic            accept, is_m, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  logic [XLEN:0]     mul_sum, div_sh;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge, q_is_div;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, m_res;

  // Opcodes beyond the 5-bit map fold onto an unused code that yields zero.
  if (OPT_W > 5) begin : g_wide_opt
    assign op_n = (|alu_opt[OPT_W-1:5]) ? OP_NONE : alu_opt[4:0];
  end else begin : g_narrow_opt
    assign op_n = 5'(alu_opt);
  end

  alu_core #(
    .XLEN      (XLEN),
    .BR_ON_OUT (BR_ON_OUT)
  ) u_core (
    .opt           (op_n),
    .a             (a),
    .b             (b),
    .result        (core_res),
    .branch_enable (core_be)
  );

  assign in_ready      = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept        = in_valid && in_ready && !flush;
  assign is_m          = is_m_op(op_n);
  assign out_valid     = (state == ST_DONE);
  assign busy          = (state == ST_CALC);
  assign out           = out_r;
  assign branch_enable = be_r;

  // The engine runs on magnitudes; signs are reapplied when the result is taken.
  assign a_neg = a[XLEN-1] && (op_n inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign b_neg = b[XLEN-1] && (op_n inside {OP_MULH, OP_DIV, OP_REM});
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign q_is_div = (op_q >= OP_DIV);
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
  assign div_sh   = {acc_hi, acc_lo[XLEN-1]};
  assign div_ge   = (div_sh >= {1'b0, mcand});
  assign div_diff = div_sh[XLEN-1:0] - mcand;

  assign prod_s = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_s  = neg_q ? -acc_lo : acc_lo;
  assign rem_s  = neg_r ? -acc_hi : acc_hi;

  always_comb begin
    m_res = '0;
    case (op_q)
      OP_MUL:                        m_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  m_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               m_res = b_zero ? '1 : quo_s;
      OP_REM, OP_REMU:               m_res = b_zero ? a_q : rem_s;
      default:                       m_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = is_m ? ST_CALC : ST_DONE;
      ST_CALC: if (cnt == CW'(XLEN)) state_nx = ST_DONE;
      ST_DONE: begin
        if (accept)                       state_nx = is_m ? ST_CALC : ST_DONE;
        else if (out_ready && !in_valid)  state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (flush) state_nx = ST_IDLE;
  end

  // One extra CALC cycle after the last iteration applies sign fix-ups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r  <= '0;
      be_r   <= 1'b0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      a_q    <= '0;
      op_q   <= OP_NONE;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
    end else if (!flush) begin
      if (accept) begin
        if (is_m) begin
          op_q   <= op_n;
          a_q    <= a;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          b_zero <= (b == '0);
          acc_hi <= '0;
          acc_lo <= (op_n >= OP_DIV) ? a_mag : b_mag;
          mcand  <= (op_n >= OP_DIV) ? b_mag : a_mag;
          cnt    <= '0;
        end else begin
          out_r <= core_res;
          be_r  <= core_be;
        end
      end else if (state == ST_CALC) begin
        if (cnt == CW'(XLEN)) begin
          out_r <= m_res;
          be_r  <= 1'b0;
        end else begin
          cnt <= cnt + CW'(1);
          if (q_is_div) begin
            acc_hi <= div_ge ? div_diff : div_sh[XLEN-1:0];
            acc_lo <= {acc_lo[XLEN-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[XLEN:1];
            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md: single-cycle ops, M ops, hold,
// flush and reset behaviour.
module tb_alu_md;
  import alu_md_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_opt;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        branch_enable;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_md #(
    .XLEN      (32),
    .OPT_W     (5),
    .BR_ON_OUT (0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_opt       (alu_opt),
    .a             (a),
    .b             (b),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out           (out),
    .branch_enable (branch_enable),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    alu_opt  = op;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    check_output("in_ready_at_request", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_single(input string tag, input logic [4:0] op, input logic [31:0] av,
                            input logic [31:0] bv, input logic [31:0] exp_out, input logic exp_be);
    apply_stimulus(op, av, bv);
    check_output({tag, "/valid"}, 64'(out_valid), 64'd1);
    check_output({tag, "/out"}, 64'(out), 64'(exp_out));
    check_output({tag, "/br"}, 64'(branch_enable), 64'(exp_be));
  endtask

  task automatic run_m(input string tag, input logic [4:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] exp_out);
    int   edges;
    logic calc_ok;
    apply_stimulus(op, av, bv);
    edges   = 0;
    calc_ok = 1'b1;
    while (!out_valid && edges < 100) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) calc_ok = 1'b0;
      @(posedge clk);
      #1;
      edges++;
    end
    check_output({tag, "/latency"}, 64'(edges), 64'd33);
    check_output({tag, "/calc_flags"}, 64'(calc_ok), 64'd1);
    check_output({tag, "/out"}, 64'(out), 64'(exp_out));
    check_output({tag, "/br"}, 64'(branch_enable), 64'd0);
  endtask

  initial begin
    int   seen;
    logic hold_ok;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    alu_opt   = '0;
    a         = '0;
    b         = '0;

    #12;
    check_output("reset/out_valid", 64'(out_valid), 64'd0);
    check_output("reset/out", 64'(out), 64'd0);
    check_output("reset/br", 64'(branch_enable), 64'd0);
    check_output("reset/busy", 64'(busy), 64'd0);
    check_output("reset/in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single-cycle operations");
    run_single("add",    OP_ADD,   32'd5,          32'd7,          32'd12,         1'b0);
    run_single("sub",    OP_SUB,   32'd5,          32'd7,          32'hFFFFFFFE,   1'b0);
    run_single("and",    OP_AND,   32'h0000F0F0,   32'h0000FF00,   32'h0000F000,   1'b0);
    run_single("or",     OP_OR,    32'h0000F0F0,   32'h0000FF00,   32'h0000FFF0,   1'b0);
    run_single("xor",    OP_XOR,   32'h0000F0F0,   32'h0000FF00,   32'h00000FF0,   1'b0);
    run_single("sll",    OP_SLL,   32'd1,          32'h00000024,   32'd16,         1'b0);
    run_single("slt",    OP_SLT,   32'hFFFFFFFF,   32'd1,          32'd1,          1'b0);
    run_single("sltu",   OP_SLTU,  32'hFFFFFFFF,   32'd1,          32'd0,          1'b0);
    run_single("srl",    OP_SRL,   32'h80000000,   32'd31,         32'd1,          1'b0);
    run_single("sra_im", OP_SHIMM, 32'h80000000,   32'd4,          32'hF8000000,   1'b0);
    run_single("sll_im", OP_SHIMM, 32'd1,          32'h00000804,   32'h00000010,   1'b0);
    run_single("addr",   OP_ADDR,  32'h00001000,   32'hFFFFFFFC,   32'h00000FFC,   1'b0);
    run_single("beq",    OP_BEQ,   32'd3,          32'd3,          32'd0,          1'b1);
    run_single("bne",    OP_BNE,   32'd3,          32'd3,          32'd0,          1'b0);
    run_single("blt",    OP_BLT,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b1);
    run_single("bltu",   OP_BLTU,  32'hFFFFFFFF,   32'd1,          32'd0,          1'b0);
    run_single("bge",    OP_BGE,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0);
    run_single("bgeu",   OP_BGEU,  32'hFFFFFFFF,   32'd1,          32'd0,          1'b1);
    run_single("passb",  OP_PASSB, 32'd9,          32'h00001234,   32'h00001234,   1'b0);
    run_single("undef",  5'h1A,    32'd9,          32'd9,          32'd0,          1'b0);

    $display("[TB] multiply / divide operations");
    run_m("mulh_minmin", OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000);
    run_m("mul_neg",     OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
    run_m("mulhu",       OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_m("mulhsu",      OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_m("div_ovf",     OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_m("rem_ovf",     OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000);
    run_m("divu_zero",   OP_DIVU,   32'd9,        32'd0,        32'hFFFFFFFF);
    run_m("remu_zero",   OP_REMU,   32'd9,        32'd0,        32'd9);
    run_m("div_trunc",   OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    run_m("rem_sign",    OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);

    $display("[TB] result held while consumer stalls");
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    run_m("divu_hold", OP_DIVU, 32'd100, 32'd7, 32'd14);
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || out !== 32'd14) hold_ok = 1'b0;
    end
    check_output("hold/stable", 64'(hold_ok), 64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("hold/released_once", 64'(out_valid), 64'd0);

    $display("[TB] flush wins over a simultaneous request");
    @(negedge clk);
    alu_opt  = OP_ADD;
    a        = 32'd1;
    b        = 32'd2;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check_output("flush_accept/out_valid", 64'(out_valid), 64'd0);

    $display("[TB] flush during divide");
    apply_stimulus(OP_DIV, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_output("flush/busy", 64'(busy), 64'd0);
    check_output("flush/in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check_output("flush/no_result", 64'(seen), 64'd0);

    $display("[TB] reset during multiply");
    apply_stimulus(OP_MUL, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("rst_mid/busy", 64'(busy), 64'd0);
    check_output("rst_mid/out_valid", 64'(out_valid), 64'd0);
    check_output("rst_mid/out", 64'(out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("rst_mid/in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check_output("rst_mid/no_result", 64'(seen), 64'd0);
    run_single("add_after", OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
